// File: rtl/gate_test_sequencer.sv
// Gate test sequencer: walks a 2-input gate through all four input vectors,
// lets each settle, samples y against an expected truth table and reports
// the mismatch count and an overall pass flag.
module gate_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXPECT_MASK   = 4'b0110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] vec_d;
    logic [2:0] err_d;
    logic       pass_d, busy_d, done_d;

    // Gate inputs come straight off the vector register, so they stay
    // registered and always match vec_idx.
    assign a = vec_idx[1];
    assign b = vec_idx[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_idx;
        err_d   = err_count;
        pass_d  = pass;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = 2'd0;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = CHECK;
            end
            CHECK: begin
                if (y != EXPECT_MASK[vec_idx]) err_d = err_count + 3'd1;
                if (vec_idx != 2'd3) begin
                    vec_d   = vec_idx + 2'd1;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end else begin
                    // Verdict includes the mismatch found on this last check.
                    pass_d  = (err_d == 3'd0);
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // busy/done are registered copies of the state we are entering.
        busy_d = (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    // Datapath and status registers; reset clears everything mid-run too.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 4'd0;
            vec_idx   <= 2'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            vec_idx   <= vec_d;
            err_count <= err_d;
            pass      <= pass_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench: per-cycle comparison of all outputs against a
// timeline model derived from vector period and gate behaviour.
module tb_gate_test_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;          // 0: default DUT, 1: SETTLE_CYCLES=1 DUT
    int   mode = 0;            // 0 xor, 1 zero, 2 xnor, 3 random table
    logic [3:0] tab = 4'h0;

    int checks = 0;
    int errors = 0;

    logic a0, b0, busy0, done0, pass0, y0;
    logic [2:0] err0;
    logic [1:0] vec0;
    logic a1, b1, busy1, done1, pass1, y1;
    logic [2:0] err1;
    logic [1:0] vec1;

    logic [9:0] last_exp;

    always #5 clk = ~clk;

    function automatic logic gate_y(int m, logic [1:0] v, logic [3:0] t);
        case (m)
            0: return v[1] ^ v[0];
            1: return 1'b0;
            2: return ~(v[1] ^ v[0]);
            default: return t[v];
        endcase
    endfunction

    always_comb y0 = gate_y(mode, {a0, b0}, tab);
    always_comb y1 = gate_y(mode, {a1, b1}, tab);

    gate_test_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start & ~sel), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_idx(vec0)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start & sel), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .vec_idx(vec1)
    );

    // {busy, done, pass, err_count, a, b, vec_idx} of the selected DUT
    logic [9:0] obs;
    always_comb obs = sel ? {busy1, done1, pass1, err1, a1, b1, vec1}
                          : {busy0, done0, pass0, err0, a0, b0, vec0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and check every cycle until two cycles after done.
    task automatic run_check(input int s, input bit repulse);
        int per, tot, v, ec, tot_err;
        logic [9:0] exp;
        per = s + 1;
        tot = 4 * per;
        tot_err = 0;
        for (int j = 0; j < 4; j++)
            if (gate_y(mode, 2'(j), tab) != (j[1] ^ j[0])) tot_err++;
        start = 1'b1;
        tick();                          // start sampled here (edge k)
        start = 1'b0;
        for (int t = 0; t <= tot + 2; t++) begin
            v  = (t < tot) ? t / per : 3;
            ec = 0;
            for (int j = 0; j < 4; j++)
                if ((j + 1) * per <= t && gate_y(mode, 2'(j), tab) != (j[1] ^ j[0])) ec++;
            exp = {(t < tot), (t == tot), (t >= tot && tot_err == 0), 3'(ec),
                   2'(v), 2'(v)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL run s=%0d mode=%0d t=%0d got=%b exp=%b", s, mode, t, obs, exp);
            end
            start = repulse && (t == 6 || t == tot - 1 || t == tot);
            tick();
        end
        start = 1'b0;
        last_exp = exp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            checks++;
            if (obs !== 10'd0) begin
                errors++;
                $display("FAIL reset dut=%0d got=%b exp=%b", i, obs, 10'd0);
            end
        end
        sel = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed_gates();
        for (int m = 0; m < 3; m++) begin
            mode = m;
            run_check(4, 1'b0);
        end
    endtask

    task automatic test_repulse();
        mode = 0;
        run_check(4, 1'b1);
    endtask

    task automatic test_mid_reset();
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b", obs, 10'd0);
        end
        for (int t = 0; t < 25; t++) begin
            checks++;
            if (obs !== 10'd0) begin
                errors++;
                $display("FAIL mid_reset_idle t=%0d got=%b exp=%b", t, obs, 10'd0);
            end
            tick();
        end
        mode = 0;
        run_check(4, 1'b0);
    endtask

    task automatic test_random_gaps();
        int gap;
        for (int r = 0; r < 6; r++) begin
            mode = 3;
            tab  = 4'($urandom);
            gap  = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                checks++;
                if (obs !== last_exp) begin
                    errors++;
                    $display("FAIL idle_hold r=%0d got=%b exp=%b", r, obs, last_exp);
                end
                tick();
            end
            run_check(4, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_short_settle();
        sel = 1'b1;
        tick();
        mode = 0;
        run_check(1, 1'b0);
        mode = 3;
        tab  = 4'($urandom);
        run_check(1, 1'b1);
        sel = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_fixed_gates();
        test_repulse();
        test_mid_reset();
        test_random_gaps();
        test_short_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles each input vector is held before y is sampled; legal range 1..15.
REQ-002 SHALL have parameter EXPECT_MASK, 4 bits, default 4'b0110: expected y per vector, bit index {a,b} (4'b0110 = XOR truth table).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begin a test run; sampled only in IDLE.
REQ-006 SHALL have port y, input, 1 bit: output of the gate under test.
REQ-007 SHALL have port a, output, 1 bit: gate input a, registered.
REQ-008 SHALL have port b, output, 1 bit: gate input b, registered.
REQ-009 SHALL have port busy, output, 1 bit: high while a run is in progress (SETTLE or CHECK).
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking run completion.
REQ-011 SHALL have port pass, output, 1 bit: 1 when the last completed run had zero mismatches.
REQ-012 SHALL have port err_count, output, 3 bits: mismatch count of the current or last run.
REQ-013 SHALL have port vec_idx, output, 2 bits: index of the vector currently driven; equals {a,b}.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETTLE, CHECK and DONE, plus a settle counter of 4 bits.
REQ-015 IDLE, start=1: next edge SHALL set vec_idx=0, a=0, b=0, err_count=0, pass=0, counter=SETTLE_CYCLES-1, and enter SETTLE.
REQ-016 IDLE, start=0: SHALL hold all outputs unchanged, including pass and err_count from the previous run.
REQ-017 SETTLE: SHALL decrement the counter each edge while it is nonzero, and SHALL enter CHECK on the edge where the counter is 0.
REQ-018 CHECK: on the next edge, SHALL increment err_count when y != EXPECT_MASK[{a,b}]; err_count does not saturate (maximum value 4).
REQ-019 CHECK with vec_idx<3: same edge SHALL increment vec_idx, drive {a,b}=new vec_idx, reload counter=SETTLE_CYCLES-1, and enter SETTLE.
REQ-020 CHECK with vec_idx=3: same edge SHALL enter DONE, leave a, b and vec_idx unchanged, and set pass=1 iff the final err_count (including this check) is 0.
REQ-021 DONE: SHALL assert done for exactly one cycle, then return to IDLE at the next edge.
REQ-022 Each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles.
REQ-023 With start sampled at edge k, done SHALL be high in the cycle following edge k+4*(SETTLE_CYCLES+1).
REQ-024 start SHALL be ignored in SETTLE, CHECK and DONE; it does not restart, extend or queue a run.
REQ-025 busy SHALL be 1 exactly in SETTLE and CHECK; busy and done SHALL never be high together.
REQ-026 a, b, busy, done, pass, err_count and vec_idx SHALL all be registered, with no combinational path from y or start.
REQ-027 err_count and pass SHALL be stable and valid in the done cycle and SHALL hold until the next accepted start.

Reset
REQ-028 rst=1 at an edge SHALL force, at that edge: state=IDLE, a=0, b=0, vec_idx=0, counter=0, busy=0, done=0, pass=0, err_count=0.
REQ-029 rst SHALL take priority over start and over every state transition, including mid-run; an aborted run SHALL produce no done pulse.
REQ-030 The first accepted start SHALL be no earlier than the first edge after rst deasserts.

Verification
REQ-031 Defaults, y=a^b model, start pulse at edge k -> vectors 00,01,10,11 each held 5 cycles; done at k+20; pass=1; err_count=0.
REQ-032 Defaults, y tied to 0 -> done at k+20; err_count=2; pass=0.
REQ-033 Defaults, y=~(a^b) -> err_count increments at every CHECK (1,2,3,4); final err_count=4; pass=0.
REQ-034 start re-pulsed at k+7 and at the done cycle -> ignored; a single done at k+20; vector timing unchanged.
REQ-035 rst asserted at k+12 (vec_idx=2) -> next cycle busy=0, a=b=0, vec_idx=0, err_count=0, no done; a new start runs cleanly.
REQ-036 SETTLE_CYCLES=1, y=a^b -> each vector held 2 cycles; done at k+8; pass=1.
